// File: rtl/pmt_lookup_ctrl.sv
// Exact-match lookup controller for the sram_pmt table: hashes keys, issues reads,
// compares tags, returns hit/miss plus action, and owns the install write port.
module pmt_lookup_ctrl #(
    parameter int unsigned           KEY_WIDTH      = 16,
    parameter int unsigned           ACT_WIDTH      = 16,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 5,
    parameter int unsigned           META_WIDTH     = 8,
    parameter logic [ACT_WIDTH-1:0]  DEFAULT_ACTION = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  lk_valid,
    output logic                  lk_ready,
    input  logic [KEY_WIDTH-1:0]  lk_key,
    input  logic [META_WIDTH-1:0] lk_meta,

    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [KEY_WIDTH-1:0]  inst_key,
    input  logic [ACT_WIDTH-1:0]  inst_action,

    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_hit,
    output logic [ACT_WIDTH-1:0]  res_action,
    output logic [META_WIDTH-1:0] res_meta,

    output logic                  sram_wr_en,
    output logic [ADDR_WIDTH-1:0] sram_wr_addr,
    output logic [DATA_WIDTH-1:0] sram_wr_data,

    output logic                  sram_rd_en,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [DATA_WIDTH-1:0] sram_rd_data,
    input  logic                  sram_rd_valid,

    output logic [15:0]           cnt_hit,
    output logic [15:0]           cnt_miss
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CMP,
        ST_RESP
    } state_t;

    state_t                state;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [META_WIDTH-1:0] meta_q;
    logic                  lk_fire;
    logic                  inst_fire;
    logic                  rd_hit;
    logic [KEY_WIDTH-1:0]  rd_tag;
    logic [ACT_WIDTH-1:0]  rd_action;

    // Fold the key onto the address in ADDR_WIDTH-bit slices; for 16/5 this is
    // key[4:0] ^ key[9:5] ^ key[14:10] ^ {4'b0, key[15]}.
    function automatic logic [ADDR_WIDTH-1:0] hash(input logic [KEY_WIDTH-1:0] k);
        logic [ADDR_WIDTH-1:0] h;
        h = '0;
        for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
            h[i % ADDR_WIDTH] = h[i % ADDR_WIDTH] ^ k[i];
        end
        return h;
    endfunction

    assign inst_ready = (state == ST_IDLE);
    assign lk_ready   = (state == ST_IDLE) && !inst_valid;
    assign inst_fire  = inst_valid && inst_ready;
    assign lk_fire    = lk_valid && lk_ready;

    always_comb begin
        sram_wr_en   = 1'b0;
        sram_wr_addr = '0;
        sram_wr_data = '0;
        if (inst_fire) begin
            sram_wr_en   = 1'b1;
            sram_wr_addr = hash(inst_key);
            sram_wr_data = {inst_key, inst_action};
        end
    end

    assign rd_tag    = sram_rd_data[DATA_WIDTH-1 -: KEY_WIDTH];
    assign rd_action = sram_rd_data[ACT_WIDTH-1:0];
    assign rd_hit    = sram_rd_valid && (rd_tag == key_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            key_q        <= '0;
            meta_q       <= '0;
            sram_rd_en   <= 1'b0;
            sram_rd_addr <= '0;
            res_valid    <= 1'b0;
            res_hit      <= 1'b0;
            res_action   <= '0;
            res_meta     <= '0;
            cnt_hit      <= '0;
            cnt_miss     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lk_fire) begin
                        key_q        <= lk_key;
                        meta_q       <= lk_meta;
                        sram_rd_en   <= 1'b1;
                        sram_rd_addr <= hash(lk_key);
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sram_rd_en   <= 1'b0;
                    sram_rd_addr <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_CMP;
                end
                ST_CMP: begin
                    res_valid  <= 1'b1;
                    res_hit    <= rd_hit;
                    res_action <= rd_hit ? rd_action : DEFAULT_ACTION;
                    res_meta   <= meta_q;
                    if (rd_hit) begin
                        if (cnt_hit != 16'hFFFF) cnt_hit <= cnt_hit + 16'd1;
                    end else begin
                        if (cnt_miss != 16'hFFFF) cnt_miss <= cnt_miss + 16'd1;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmt_lookup_ctrl.sv
// Directed bench for pmt_lookup_ctrl with a two-cycle-latency table model
// carrying a per-entry valid bit.
module tb_pmt_lookup_ctrl;

    logic        clk;
    logic        rst_n;
    logic        lk_valid;
    logic        lk_ready;
    logic [15:0] lk_key;
    logic [7:0]  lk_meta;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_key;
    logic [15:0] inst_action;
    logic        res_valid;
    logic        res_ready;
    logic        res_hit;
    logic [15:0] res_action;
    logic [7:0]  res_meta;
    logic        sram_wr_en;
    logic [4:0]  sram_wr_addr;
    logic [31:0] sram_wr_data;
    logic        sram_rd_en;
    logic [4:0]  sram_rd_addr;
    logic [31:0] sram_rd_data;
    logic        sram_rd_valid;
    logic [15:0] cnt_hit;
    logic [15:0] cnt_miss;

    int n_checks = 0;
    int n_fail   = 0;

    pmt_lookup_ctrl #(
        .KEY_WIDTH(16), .ACT_WIDTH(16), .DATA_WIDTH(32), .ADDR_WIDTH(5),
        .META_WIDTH(8), .DEFAULT_ACTION(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key), .lk_meta(lk_meta),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_key(inst_key),
        .inst_action(inst_action),
        .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
        .res_action(res_action), .res_meta(res_meta),
        .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data), .sram_rd_valid(sram_rd_valid),
        .cnt_hit(cnt_hit), .cnt_miss(cnt_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table model: write takes effect at the edge, read returns two cycles after rd_en.
    logic [31:0] mem [32];
    logic        vld [32];
    logic        p1_en;
    logic [4:0]  p1_addr;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            vld[i] = 1'b0;
        end
        p1_en         = 1'b0;
        p1_addr       = '0;
        sram_rd_data  = '0;
        sram_rd_valid = 1'b0;
    end

    always @(posedge clk) begin
        sram_rd_data  <= mem[p1_addr];
        sram_rd_valid <= p1_en && vld[p1_addr];
        p1_en         <= sram_rd_en;
        p1_addr       <= sram_rd_addr;
        if (sram_wr_en) begin
            mem[sram_wr_addr] <= sram_wr_data;
            vld[sram_wr_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (sram_rd_en && sram_wr_en) begin
                n_fail++;
                $display("FAIL rd_wr_exclusive: rd_en=%0b wr_en=%0b required not both 1 at %0t",
                         sram_rd_en, sram_wr_en, $time);
            end
        end
    end

    task automatic send_lookup(input logic [15:0] k, input logic [7:0] m, output bit ok);
        @(negedge clk);
        lk_valid = 1'b1;
        lk_key   = k;
        lk_meta  = m;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (lk_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 lk_valid = 1'b0;
    endtask

    task automatic await_result(output int lat, output logic [4:0] addr_seen, output int rd_cnt);
        lat       = 0;
        rd_cnt    = 0;
        addr_seen = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (sram_rd_en) begin
                rd_cnt++;
                addr_seen = sram_rd_addr;
            end
            if (res_valid) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        lk_valid = 0; lk_key = '0; lk_meta = '0;
        inst_valid = 0; inst_key = '0; inst_action = '0;
        res_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({lk_ready, inst_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready: lk_ready=%0b inst_ready=%0b required 1 1", lk_ready, inst_ready);
        end
        n_checks++;
        if ({res_valid, res_hit, res_action, res_meta} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_res: valid=%0b hit=%0b action=%h meta=%h required all 0",
                     res_valid, res_hit, res_action, res_meta);
        end
        n_checks++;
        if ({sram_wr_en, sram_wr_addr, sram_wr_data, sram_rd_en, sram_rd_addr} !== 44'd0) begin
            n_fail++;
            $display("FAIL reset_sram: wr_en=%0b wr_addr=%h wr_data=%h rd_en=%0b rd_addr=%h required all 0",
                     sram_wr_en, sram_wr_addr, sram_wr_data, sram_rd_en, sram_rd_addr);
        end
        n_checks++;
        if ({cnt_hit, cnt_miss} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: hit=%h miss=%h required 0 0", cnt_hit, cnt_miss);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_install_hit();
        bit ok; int lat; int rdc; logic [4:0] ra;
        @(negedge clk);
        inst_valid = 1'b1; inst_key = 16'h1234; inst_action = 16'hBEEF;
        #1;
        n_checks++;
        if (sram_wr_en !== 1'b1 || sram_wr_addr !== 5'd1 || sram_wr_data !== 32'h1234BEEF ||
            lk_ready !== 1'b0 || inst_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL install_write: wr_en=%0b addr=%h data=%h lk_ready=%0b inst_ready=%0b required 1 01 1234beef 0 1",
                     sram_wr_en, sram_wr_addr, sram_wr_data, lk_ready, inst_ready);
        end
        @(posedge clk);
        #1 inst_valid = 1'b0;
        send_lookup(16'h1234, 8'h5A, ok);
        await_result(lat, ra, rdc);
        n_checks++;
        if (!ok || lat !== 4 || rdc !== 1 || ra !== 5'd1) begin
            n_fail++;
            $display("FAIL hit_latency: accepted=%0b lat=%0d rd_cycles=%0d rd_addr=%h required 1 4 1 01",
                     ok, lat, rdc, ra);
        end
        n_checks++;
        if (res_hit !== 1'b1 || res_action !== 16'hBEEF || res_meta !== 8'h5A ||
            cnt_hit !== 16'd1 || cnt_miss !== 16'd0) begin
            n_fail++;
            $display("FAIL hit_result: hit=%0b action=%h meta=%h cnt_hit=%0d cnt_miss=%0d required 1 beef 5a 1 0",
                     res_hit, res_action, res_meta, cnt_hit, cnt_miss);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || lk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_return_idle: res_valid=%0b lk_ready=%0b required 0 1", res_valid, lk_ready);
        end
    endtask

    task automatic test_miss(input logic [15:0] k, input logic [7:0] m, input logic [4:0] exp_addr,
                             input logic [15:0] exp_miss, input logic [15:0] exp_hit);
        bit ok; int lat; int rdc; logic [4:0] ra;
        send_lookup(k, m, ok);
        await_result(lat, ra, rdc);
        n_checks++;
        if (!ok || lat !== 4 || ra !== exp_addr) begin
            n_fail++;
            $display("FAIL miss_issue key=%h: accepted=%0b lat=%0d rd_addr=%h required 1 4 %h",
                     k, ok, lat, ra, exp_addr);
        end
        n_checks++;
        if (res_hit !== 1'b0 || res_action !== 16'h0000 || res_meta !== m ||
            cnt_miss !== exp_miss || cnt_hit !== exp_hit) begin
            n_fail++;
            $display("FAIL miss_result key=%h: hit=%0b action=%h meta=%h cnt_miss=%h cnt_hit=%h required 0 0000 %h %h %h",
                     k, res_hit, res_action, res_meta, cnt_miss, cnt_hit, m, exp_miss, exp_hit);
        end
    endtask

    task automatic test_priority();
        int lat; int rdc; logic [4:0] ra;
        @(negedge clk);
        inst_valid = 1'b1; inst_key = 16'h00FF; inst_action = 16'hCAFE;
        lk_valid = 1'b1; lk_key = 16'h00FF; lk_meta = 8'h33;
        #1;
        n_checks++;
        if (lk_ready !== 1'b0 || inst_ready !== 1'b1 || sram_wr_en !== 1'b1 ||
            sram_wr_addr !== 5'h18 || sram_wr_data !== 32'h00FFCAFE) begin
            n_fail++;
            $display("FAIL priority_install: lk_ready=%0b inst_ready=%0b wr_en=%0b addr=%h data=%h required 0 1 1 18 00ffcafe",
                     lk_ready, inst_ready, sram_wr_en, sram_wr_addr, sram_wr_data);
        end
        @(posedge clk);
        #1 inst_valid = 1'b0;
        #1;
        n_checks++;
        if (lk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL priority_lk_next: lk_ready=%0b required 1", lk_ready);
        end
        @(posedge clk);
        #1 lk_valid = 1'b0;
        await_result(lat, ra, rdc);
        n_checks++;
        if (lat !== 4 || ra !== 5'h18 || res_hit !== 1'b1 || res_action !== 16'hCAFE ||
            res_meta !== 8'h33 || cnt_hit !== 16'd2) begin
            n_fail++;
            $display("FAIL priority_hit: lat=%0d rd_addr=%h hit=%0b action=%h meta=%h cnt_hit=%0d required 4 18 1 cafe 33 2",
                     lat, ra, res_hit, res_action, res_meta, cnt_hit);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] rdy;
        logic [9:0] rv;
        @(negedge clk);
        lk_valid = 1'b1; lk_key = 16'h1234; lk_meta = 8'h44;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            rdy[i] = lk_ready;
            rv[i]  = res_valid;
        end
        lk_valid = 1'b0;
        n_checks++;
        if (rdy !== 10'b0000100001 || rv !== 10'b1000010000) begin
            n_fail++;
            $display("FAIL b2b_spacing: ready=%b res_valid=%b required 0000100001 1000010000", rdy, rv);
        end
        n_checks++;
        if (res_hit !== 1'b1 || res_action !== 16'hBEEF || res_meta !== 8'h44 || cnt_hit !== 16'd4) begin
            n_fail++;
            $display("FAIL b2b_result: hit=%0b action=%h meta=%h cnt_hit=%0d required 1 beef 44 4",
                     res_hit, res_action, res_meta, cnt_hit);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        bit ok; int lat; int rdc; logic [4:0] ra;
        res_ready = 1'b0;
        send_lookup(16'h1234, 8'h77, ok);
        await_result(lat, ra, rdc);
        n_checks++;
        if (!ok || lat !== 4 || cnt_hit !== 16'd5) begin
            n_fail++;
            $display("FAIL stall_enter: accepted=%0b lat=%0d cnt_hit=%0d required 1 4 5", ok, lat, cnt_hit);
        end
        inst_valid = 1'b1; inst_key = 16'h1234; inst_action = 16'hDEAD;
        lk_valid = 1'b1; lk_key = 16'h0001; lk_meta = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (res_valid !== 1'b1 || res_hit !== 1'b1 || res_action !== 16'hBEEF ||
                res_meta !== 8'h77 || lk_ready !== 1'b0 || inst_ready !== 1'b0 || sram_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d: v=%0b hit=%0b act=%h meta=%h lk_rdy=%0b inst_rdy=%0b wr_en=%0b required 1 1 beef 77 0 0 0",
                         i, res_valid, res_hit, res_action, res_meta, lk_ready, inst_ready, sram_wr_en);
            end
        end
        inst_valid = 1'b0;
        lk_valid   = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || lk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: res_valid=%0b lk_ready=%0b required 0 1", res_valid, lk_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_lookup(16'h1234, 8'h99, ok);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok || res_valid !== 1'b0 || sram_rd_en !== 1'b0 || lk_ready !== 1'b1 ||
            cnt_hit !== 16'd0 || cnt_miss !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_assert: accepted=%0b res_valid=%0b rd_en=%0b lk_ready=%0b hit=%0d miss=%0d required 1 0 0 1 0 0",
                     ok, res_valid, sram_rd_en, lk_ready, cnt_hit, cnt_miss);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (res_valid !== 1'b0 || lk_ready !== 1'b1 || cnt_hit !== 16'd0 || cnt_miss !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc=%0d: res_valid=%0b lk_ready=%0b hit=%0d miss=%0d required 0 1 0 0",
                         i, res_valid, lk_ready, cnt_hit, cnt_miss);
            end
        end
    endtask

    task automatic test_saturation();
        bit ok; int lat; int rdc; logic [4:0] ra;
        @(negedge clk);
        force dut.cnt_hit = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_hit;
        send_lookup(16'h1234, 8'h01, ok);
        await_result(lat, ra, rdc);
        n_checks++;
        if (!ok || res_hit !== 1'b1 || cnt_hit !== 16'hFFFF || cnt_miss !== 16'd0) begin
            n_fail++;
            $display("FAIL sat_hit: accepted=%0b hit=%0b cnt_hit=%h cnt_miss=%h required 1 1 ffff 0000",
                     ok, res_hit, cnt_hit, cnt_miss);
        end
        @(negedge clk);
        force dut.cnt_miss = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_miss;
        test_miss(16'h0001, 8'h02, 5'd1, 16'hFFFF, 16'hFFFF);
        test_miss(16'h0001, 8'h03, 5'd1, 16'hFFFF, 16'hFFFF);
    endtask

    initial begin
        test_reset();
        test_install_hit();
        test_miss(16'h00FF, 8'h11, 5'h18, 16'd1, 16'd1);
        test_miss(16'h0001, 8'h22, 5'd1,  16'd2, 16'd1);
        test_miss(16'h0000, 8'h23, 5'd0,  16'd3, 16'd1);
        test_priority();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_saturation();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
